// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and the pending-write counter limit used by the
// writeback scoreboard and its per-register counters.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    // Largest value a CNT_W-bit pending counter may hold.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNT_W);

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of writes in flight to one architectural register.
module pending_counter #(
    parameter int CNT_W = pipeline_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);
    import pipeline_pkg::*;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] count;

    // Simultaneous inc and dec cancel; either alone stops at its end of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && (count != LIMIT)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        zero = (count == '0);
        full = (count == LIMIT);
    end

endmodule

// File: rtl/writeback_scoreboard.sv
// MEM/WB pipeline register plus a per-register pending-write scoreboard that
// stalls ID on read-after-write hazards and throttles issue per destination.
module writeback_scoreboard #(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int REG_AW = pipeline_pkg::REG_AW,
    parameter int CNT_W  = pipeline_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Issue_EN,
    input  logic [REG_AW-1:0] Issue_Dest,
    output logic              Issue_Ready,
    input  logic [REG_AW-1:0] Src1,
    input  logic [REG_AW-1:0] Src2,
    input  logic              Two_Src,
    output logic              Hazard,
    input  logic              MEM_WB_EN,
    input  logic              MEM_R_EN,
    input  logic [REG_AW-1:0] MEM_Dest,
    input  logic [DATA_W-1:0] MEM_ALU_Res,
    input  logic [DATA_W-1:0] MEM_Mem_Data,
    input  logic              Freeze,
    output logic              Write_EN,
    output logic [REG_AW-1:0] Dest,
    output logic [DATA_W-1:0] Write_Val
);
    import pipeline_pkg::*;

    localparam int NUM_REGS = 1 << REG_AW;

    logic                retire;
    logic [DATA_W-1:0]   wb_data;
    logic [NUM_REGS-1:0] idle;
    logic [NUM_REGS-1:0] full;

    always_comb begin
        retire  = !Freeze && MEM_WB_EN && (MEM_Dest != '0);
        wb_data = MEM_R_EN ? MEM_Mem_Data : MEM_ALU_Res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Write_EN  <= 1'b0;
            Dest      <= '0;
            Write_Val <= '0;
        end else if (!Freeze) begin
            Write_EN  <= MEM_WB_EN && (MEM_Dest != '0);
            Dest      <= MEM_Dest;
            Write_Val <= wb_data;
        end
    end

    // Register 0 is hardwired: never pending, never full.
    assign idle[0] = 1'b1;
    assign full[0] = 1'b0;

    // The inc request is not gated by Issue_Ready: a full counter saturates on
    // its own, and an issue paired with a retire of the same register holds.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        pending_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (Issue_EN && (Issue_Dest == REG_AW'(r))),
            .dec  (retire && (MEM_Dest == REG_AW'(r))),
            .zero (idle[r]),
            .full (full[r])
        );
    end

    always_comb begin
        Issue_Ready = !full[Issue_Dest];
        Hazard      = !idle[Src1] || (Two_Src && !idle[Src2]);
    end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Randomized and directed bench for writeback_scoreboard against a
// per-register pending-count model.
module tb_writeback_scoreboard;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 32;
    localparam int MAXC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          Issue_EN;
    logic [AW-1:0] Issue_Dest;
    logic          Issue_Ready;
    logic [AW-1:0] Src1;
    logic [AW-1:0] Src2;
    logic          Two_Src;
    logic          Hazard;
    logic          MEM_WB_EN;
    logic          MEM_R_EN;
    logic [AW-1:0] MEM_Dest;
    logic [DW-1:0] MEM_ALU_Res;
    logic [DW-1:0] MEM_Mem_Data;
    logic          Freeze;
    logic          Write_EN;
    logic [AW-1:0] Dest;
    logic [DW-1:0] Write_Val;

    writeback_scoreboard #(
        .DATA_W(DW),
        .REG_AW(AW),
        .CNT_W (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Issue_EN     (Issue_EN),
        .Issue_Dest   (Issue_Dest),
        .Issue_Ready  (Issue_Ready),
        .Src1         (Src1),
        .Src2         (Src2),
        .Two_Src      (Two_Src),
        .Hazard       (Hazard),
        .MEM_WB_EN    (MEM_WB_EN),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_Dest     (MEM_Dest),
        .MEM_ALU_Res  (MEM_ALU_Res),
        .MEM_Mem_Data (MEM_Mem_Data),
        .Freeze       (Freeze),
        .Write_EN     (Write_EN),
        .Dest         (Dest),
        .Write_Val    (Write_Val)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int            mcnt [NR];
    logic          m_we;
    logic [AW-1:0] m_dest;
    logic [DW-1:0] m_val;
    bit            mvalid = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [AW-1:0] r);
        return (r != 0) && (mcnt[r] != 0);
    endfunction

    task automatic compare();
        chk("issue_ready", DW'(Issue_Ready), DW'(mcnt[Issue_Dest] != MAXC));
        chk("hazard", DW'(Hazard), DW'(pending(Src1) || (Two_Src && pending(Src2))));
        chk("write_en", DW'(Write_EN), DW'(m_we));
        chk("dest", DW'(Dest), DW'(m_dest));
        chk("write_val", Write_Val, m_val);
    endtask

    task automatic model_edge();
        bit iss;
        bit ret;
        if (rst) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            m_we   = 1'b0;
            m_dest = '0;
            m_val  = '0;
        end else begin
            iss = Issue_EN && (Issue_Dest != 0);
            ret = !Freeze && MEM_WB_EN && (MEM_Dest != 0);
            if (!(iss && ret && Issue_Dest == MEM_Dest)) begin
                if (iss && mcnt[Issue_Dest] < MAXC) mcnt[Issue_Dest]++;
                if (ret && mcnt[MEM_Dest] > 0) mcnt[MEM_Dest]--;
            end
            if (!Freeze) begin
                m_we   = MEM_WB_EN && (MEM_Dest != 0);
                m_dest = MEM_Dest;
                m_val  = MEM_R_EN ? MEM_Mem_Data : MEM_ALU_Res;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (mvalid) compare();
        @(posedge clk);
        model_edge();
        mvalid = 1'b1;
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; Issue_EN = 1'b0; Issue_Dest = '0; Src1 = '0; Src2 = '0; Two_Src = 1'b0;
        MEM_WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_Dest = '0; MEM_ALU_Res = '0; MEM_Mem_Data = '0;
        Freeze = 1'b0;

        // reset for two cycles
        cycle();
        cycle();
        rst = 1'b0;
        settle();
        chk("rst_write_en", DW'(Write_EN), 0);
        chk("rst_hazard", DW'(Hazard), 0);
        chk("rst_ready", DW'(Issue_Ready), 1);

        // issue 5, then RAW hazard, then retire it
        Issue_EN = 1'b1; Issue_Dest = 5'd5;
        cycle();
        Issue_EN = 1'b0; Src1 = 5'd5;
        settle();
        chk("raw_hazard", DW'(Hazard), 1);
        MEM_WB_EN = 1'b1; MEM_Dest = 5'd5; MEM_ALU_Res = 32'h1234;
        cycle();
        MEM_WB_EN = 1'b0;
        settle();
        chk("ret_write_en", DW'(Write_EN), 1);
        chk("ret_dest", DW'(Dest), 5);
        chk("ret_val", Write_Val, 32'h1234);
        chk("ret_hazard", DW'(Hazard), 0);

        // load selects memory data; retire of an idle register is harmless
        MEM_WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_Dest = 5'd3;
        MEM_Mem_Data = 32'hDEADBEEF; MEM_ALU_Res = 32'h40;
        cycle();
        MEM_WB_EN = 1'b0; MEM_R_EN = 1'b0;
        settle();
        chk("load_val", Write_Val, 32'hDEADBEEF);

        // saturate register 7
        Issue_EN = 1'b1; Issue_Dest = 5'd7; Src1 = '0;
        repeat (3) cycle();
        settle();
        chk("full_ready", DW'(Issue_Ready), 0);
        MEM_WB_EN = 1'b1; MEM_Dest = 5'd7;
        cycle();
        Issue_EN = 1'b0; MEM_WB_EN = 1'b0; Src1 = 5'd7;
        settle();
        chk("same_reg_hold", DW'(Issue_Ready), 0);
        chk("full_hazard", DW'(Hazard), 1);
        MEM_WB_EN = 1'b1;
        cycle();
        MEM_WB_EN = 1'b0;
        settle();
        chk("drain_ready", DW'(Issue_Ready), 1);

        // register 0 is never tracked or written
        Issue_EN = 1'b1; Issue_Dest = '0; MEM_WB_EN = 1'b1; MEM_Dest = '0;
        MEM_ALU_Res = 32'hAAAA; Src1 = '0; Src2 = '0; Two_Src = 1'b1;
        settle();
        chk("r0_hazard", DW'(Hazard), 0);
        chk("r0_ready", DW'(Issue_Ready), 1);
        cycle();
        settle();
        chk("r0_write_en", DW'(Write_EN), 0);

        // freeze holds outputs and counters; reset beats freeze
        Issue_Dest = 5'd9; MEM_WB_EN = 1'b0; Two_Src = 1'b0;
        cycle();
        Issue_EN = 1'b0; Freeze = 1'b1; MEM_WB_EN = 1'b1; MEM_Dest = 5'd9;
        MEM_ALU_Res = 32'h55; Src1 = 5'd9;
        cycle();
        settle();
        chk("frz_write_en", DW'(Write_EN), 0);
        chk("frz_dest", DW'(Dest), 0);
        chk("frz_val", Write_Val, 32'hAAAA);
        chk("frz_hazard", DW'(Hazard), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0; Freeze = 1'b0; MEM_WB_EN = 1'b0;
        settle();
        chk("frz_rst_val", Write_Val, 0);
        chk("frz_rst_hazard", DW'(Hazard), 0);
        chk("frz_rst_ready", DW'(Issue_Ready), 1);

        // random traffic over a few registers to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            Issue_EN     = $urandom_range(0, 1);
            Issue_Dest   = AW'($urandom_range(0, 5));
            Src1         = AW'($urandom_range(0, 5));
            Src2         = AW'($urandom_range(0, 5));
            Two_Src      = $urandom_range(0, 1);
            MEM_WB_EN    = $urandom_range(0, 1);
            MEM_R_EN     = $urandom_range(0, 1);
            MEM_Dest     = AW'($urandom_range(0, 5));
            MEM_ALU_Res  = $urandom;
            MEM_Mem_Data = $urandom;
            Freeze       = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
